// File: rtl/window3x3_gen.sv
// window3x3_gen: 3x3 sliding-window generator over a raster pixel stream using two line buffers.
// Ports: clk; rst (async, active low); in_valid/in_pix raster input, no backpressure;
//   op1..op9 registered 3x3 window, row-major (op1 top-left, op9 bottom-right);
//   out_valid one-cycle pulse when op1..op9 hold a complete window (1 cycle after the accepting edge);
//   frame_done (only when WINDOW_FRAME_DONE_EN is defined) pulses with the window whose op9 is p(H-1,W-1).
module window3x3_gen #(
  parameter int N = 8,
  parameter int W = 64,
  parameter int H = 64
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  input  logic [N-1:0] in_pix,
  output logic [N-1:0] op1,
  output logic [N-1:0] op2,
  output logic [N-1:0] op3,
  output logic [N-1:0] op4,
  output logic [N-1:0] op5,
  output logic [N-1:0] op6,
  output logic [N-1:0] op7,
  output logic [N-1:0] op8,
  output logic [N-1:0] op9,
`ifdef WINDOW_FRAME_DONE_EN
  output logic         frame_done,
`endif
  output logic         out_valid
);
  localparam int CW = $clog2(W);
  localparam int RW = $clog2(H);
  logic [CW-1:0] col;
  logic [RW-1:0] row;
  logic [N-1:0] lb1 [W];
  logic [N-1:0] lb2 [W];
  logic [N-1:0] w [9];
  logic [N-1:0] o [9];
  logic [N-1:0] nw [9];
  logic last_col, last_row, win_ok;
  always_comb begin
    last_col = col == CW'(W - 1);
    last_row = row == RW'(H - 1);
    win_ok   = row >= RW'(2) && col >= CW'(2);
    nw[0] = w[1];
    nw[1] = w[2];
    nw[2] = lb2[col];
    nw[3] = w[4];
    nw[4] = w[5];
    nw[5] = lb1[col];
    nw[6] = w[7];
    nw[7] = w[8];
    nw[8] = in_pix;
  end
  // Line buffers are never reset: rows 0 and 1 of each frame are gated off, so stale data never reaches a window.
  always_ff @(posedge clk) begin
    if (in_valid) begin
      lb2[col] <= lb1[col];
      lb1[col] <= in_pix;
    end
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      col       <= '0;
      row       <= '0;
      out_valid <= 1'b0;
      for (int i = 0; i < 9; i++) begin
        w[i] <= '0;
        o[i] <= '0;
      end
    end else begin
      out_valid <= in_valid && win_ok;
      if (in_valid) begin
        col <= last_col ? '0 : col + CW'(1);
        row <= last_col ? (last_row ? '0 : row + RW'(1)) : row;
        w   <= nw;
        if (win_ok) o <= nw;
      end
    end
  end
`ifdef WINDOW_FRAME_DONE_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) frame_done <= 1'b0;
    else      frame_done <= in_valid && last_col && last_row;
  end
`endif
  assign op1 = o[0];
  assign op2 = o[1];
  assign op3 = o[2];
  assign op4 = o[3];
  assign op5 = o[4];
  assign op6 = o[5];
  assign op7 = o[6];
  assign op8 = o[7];
  assign op9 = o[8];
endmodule
